// File: rtl/bist_pkg.sv
// Shared definitions for the BIST response analyzer: FSM states, default constants and the
// MISR step function used by both the RTL and the reference model.
package bist_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArmed   = 2'd1,
        StCompact = 2'd2,
        StDone    = 2'd3
    } bra_state_e;

    localparam logic [15:0] DEF_POLY   = 16'h1021;
    localparam logic [15:0] DEF_GOLDEN = 16'hA5C3;

    // One MISR step on a sig_w-bit register (sig_w <= 32); d must already fit in sig_w bits.
    function automatic logic [31:0] misr_next(input logic [31:0] s, input logic [31:0] d,
                                              input logic [31:0] poly,
                                              input int unsigned sig_w);
        logic [31:0] mask;
        logic [31:0] r;
        mask = (sig_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << sig_w) - 32'd1);
        r    = (s << 1) & mask;
        if (((s >> (sig_w - 1)) & 32'd1) != 32'd0) begin
            r = r ^ (poly & mask);
        end
        return (r ^ d) & mask;
    endfunction

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register: load has priority over compaction, reset reloads SEED.
module bist_misr
    import bist_pkg::*;
#(
    parameter int unsigned      DATA_W = 8,
    parameter int unsigned      SIG_W  = 16,
    parameter logic [SIG_W-1:0] POLY   = SIG_W'(DEF_POLY),
    parameter logic [SIG_W-1:0] SEED   = {SIG_W{1'b1}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    output logic [SIG_W-1:0]  sig
);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (load) begin
            sig_d = SEED;
        end else if (en) begin
            sig_d = SIG_W'(misr_next(32'(sig_q), 32'(d), 32'(POLY), SIG_W));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sig_q <= SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/bist_response_analyzer.sv
// BIST response analyzer: compacts CUT outputs into a MISR and registers a pass/fail verdict.
// Define BRA_SIG_READBACK_EN to expose the live signature and capture count as sig_out/cnt_out.
module bist_response_analyzer
    import bist_pkg::*;
#(
    parameter int unsigned      DATA_W = 8,
    parameter int unsigned      SIG_W  = 16,
    parameter logic [SIG_W-1:0] POLY   = SIG_W'(DEF_POLY),
    parameter logic [SIG_W-1:0] SEED   = {SIG_W{1'b1}},
    parameter logic [SIG_W-1:0] GOLDEN = SIG_W'(DEF_GOLDEN),
    parameter int unsigned      NCLOCK = 650
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic              running,
    input  logic              finish,
    input  logic [DATA_W-1:0] cut_out,
    output logic              result_valid,
    output logic              pass_fail,
    output logic              count_err
`ifdef BRA_SIG_READBACK_EN
    ,
    output logic [SIG_W-1:0]           sig_out,
    output logic [$clog2(NCLOCK)+1:0]  cnt_out
`endif
);

    // Two spare bits so a saturated count can never equal NCLOCK.
    localparam int unsigned      CNT_W      = $clog2(NCLOCK) + 2;
    localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(NCLOCK);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    bra_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             result_valid_q, result_valid_d;
    logic             pass_fail_q, pass_fail_d;
    logic             count_err_q, count_err_d;
    logic             capture;
    logic             active;
    logic [SIG_W-1:0] sig;

    assign active = (state_q == StArmed) || (state_q == StCompact);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        result_valid_d = result_valid_q;
        pass_fail_d    = pass_fail_q;
        count_err_d    = count_err_q;
        capture        = 1'b0;
        if (init) begin
            state_d        = StArmed;
            cnt_d          = '0;
            result_valid_d = 1'b0;
            pass_fail_d    = 1'b0;
            count_err_d    = 1'b0;
        end else if (active && finish) begin
            count_err_d    = (cnt_q != CNT_TARGET);
            pass_fail_d    = (sig == GOLDEN) && (cnt_q == CNT_TARGET);
            result_valid_d = 1'b1;
            state_d        = StDone;
        end else if (active && running) begin
            capture = 1'b1;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_ONE;
            end
            state_d = StCompact;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            result_valid_q <= 1'b0;
            pass_fail_q    <= 1'b0;
            count_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            result_valid_q <= result_valid_d;
            pass_fail_q    <= pass_fail_d;
            count_err_q    <= count_err_d;
        end
    end

    bist_misr #(
        .DATA_W(DATA_W),
        .SIG_W (SIG_W),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clk  (clk),
        .reset(reset),
        .load (init),
        .en   (capture),
        .d    (cut_out),
        .sig  (sig)
    );

    assign result_valid = result_valid_q;
    assign pass_fail    = pass_fail_q;
    assign count_err    = count_err_q;

`ifdef BRA_SIG_READBACK_EN
    assign sig_out = sig;
    assign cnt_out = cnt_q;
`endif

endmodule

// File: tb/tb_bist_response_analyzer.sv
// Directed bench for bist_response_analyzer with a verdict scoreboard and a MISR reference model.
module tb_bist_response_analyzer;
    import bist_pkg::*;

    localparam int unsigned DW     = 4;
    localparam int unsigned SW     = 8;
    localparam logic [7:0]  POLY   = 8'h1D;
    localparam logic [7:0]  SEED   = 8'h00;
    localparam logic [7:0]  GOLDEN = 8'h00;
    localparam int unsigned NCLK   = 4;

    typedef struct packed {
        logic rv;
        logic pf;
        logic ce;
    } verdict_t;

    logic clk = 1'b0;
    logic reset, init, running, finish;
    logic [DW-1:0] cut_out;
    logic rv, pf, ce;
    logic fb_init, fb_running, fb_finish;
    logic [DW-1:0] fb_cut;
    logic fb_rv, fb_pf, fb_ce;
`ifdef BRA_SIG_READBACK_EN
    logic [SW-1:0] sig_out, fb_sig_out;
    logic [3:0]    cnt_out;
    logic [1:0]    fb_cnt_out;
`endif

    int tests = 0;
    int failures = 0;
    verdict_t exp_q[$];
    logic [SW-1:0] sig_m;
    int unsigned   cnt_m;

    always #5 clk = ~clk;

    bist_response_analyzer #(
        .DATA_W(DW), .SIG_W(SW), .POLY(POLY), .SEED(SEED), .GOLDEN(GOLDEN), .NCLOCK(NCLK)
    ) dut (
        .clk(clk), .reset(reset), .init(init), .running(running), .finish(finish),
        .cut_out(cut_out), .result_valid(rv), .pass_fail(pf), .count_err(ce)
`ifdef BRA_SIG_READBACK_EN
        , .sig_out(sig_out), .cnt_out(cnt_out)
`endif
    );

    bist_response_analyzer #(
        .DATA_W(DW), .SIG_W(SW), .POLY(8'h1D), .SEED(8'h80), .GOLDEN(8'h1D), .NCLOCK(1)
    ) dut_fb (
        .clk(clk), .reset(reset), .init(fb_init), .running(fb_running), .finish(fb_finish),
        .cut_out(fb_cut), .result_valid(fb_rv), .pass_fail(fb_pf), .count_err(fb_ce)
`ifdef BRA_SIG_READBACK_EN
        , .sig_out(fb_sig_out), .cnt_out(fb_cnt_out)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_init();
        init = 1'b1;
        cycle();
        init = 1'b0;
        sig_m = SEED;
        cnt_m = 0;
    endtask

    task automatic run(input logic [DW-1:0] data);
        running = 1'b1;
        cut_out = data;
        sig_m = SW'(misr_next(32'(sig_m), 32'(data), 32'(POLY), SW));
        cnt_m++;
        cycle();
        running = 1'b0;
        cut_out = '0;
    endtask

    task automatic do_finish(input string tag);
        verdict_t v;
        exp_q.push_back('{rv: 1'b1, pf: (sig_m == GOLDEN) && (cnt_m == NCLK),
                          ce: (cnt_m != NCLK)});
        finish = 1'b1;
        cycle();
        finish = 1'b0;
        v = exp_q.pop_front();
        check({tag, ".result_valid"}, 32'(rv), 32'(v.rv));
        check({tag, ".pass_fail"}, 32'(pf), 32'(v.pf));
        check({tag, ".count_err"}, 32'(ce), 32'(v.ce));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; init = 1'b0; running = 1'b0; finish = 1'b0; cut_out = '0;
        fb_init = 1'b0; fb_running = 1'b0; fb_finish = 1'b0; fb_cut = '0;
        sig_m = SEED; cnt_m = 0;
        cycle();
        cycle();
        check("reset.result_valid", 32'(rv), 32'd0);
        check("reset.pass_fail", 32'(pf), 32'd0);
        check("reset.count_err", 32'(ce), 32'd0);
        check("reset.state", 32'(dut.state_q), 32'(StIdle));
        check("reset.sig", 32'(dut.sig), 32'(SEED));
        reset = 1'b0;

        // Clean pass, then verify DONE ignores running/finish.
        do_init();
        for (int i = 0; i < 4; i++) run(4'h0);
        do_finish("clean");
        running = 1'b1; finish = 1'b1; cut_out = 4'hF;
        cycle();
        running = 1'b0; finish = 1'b0; cut_out = '0;
        check("done_hold.result_valid", 32'(rv), 32'd1);
        check("done_hold.pass_fail", 32'(pf), 32'd1);
        check("done_hold.sig", 32'(dut.sig), 32'h00);

        // Single-bit fault on the first capture.
        do_init();
        check("fault.init_clears_valid", 32'(rv), 32'd0);
        run(4'h1);
        for (int i = 0; i < 3; i++) run(4'h0);
        check("fault.sig", 32'(dut.sig), 32'h08);
`ifdef BRA_SIG_READBACK_EN
        check("fault.sig_out", 32'(sig_out), 32'h08);
        check("fault.cnt_out", 32'(cnt_out), 32'd4);
`endif
        do_finish("fault");

        // Count mismatch.
        do_init();
        for (int i = 0; i < 3; i++) run(4'h0);
        do_finish("short");

        // Feedback path on the second instance.
        fb_init = 1'b1;
        cycle();
        fb_init = 1'b0;
        fb_running = 1'b1; fb_cut = 4'h0;
        cycle();
        fb_running = 1'b0;
        check("feedback.sig", 32'(dut_fb.sig), 32'h1D);
        fb_finish = 1'b1;
        cycle();
        fb_finish = 1'b0;
        check("feedback.result_valid", 32'(fb_rv), 32'd1);
        check("feedback.pass_fail", 32'(fb_pf), 32'd1);
        check("feedback.count_err", 32'(fb_ce), 32'd0);

        // Reset mid-session.
        do_init();
        run(4'h3);
        run(4'h5);
        check("midreset.pre_state", 32'(dut.state_q), 32'(StCompact));
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("midreset.result_valid", 32'(rv), 32'd0);
        check("midreset.state", 32'(dut.state_q), 32'(StIdle));
        check("midreset.sig", 32'(dut.sig), 32'(SEED));
        finish = 1'b1;
        cycle();
        finish = 1'b0;
        check("idle_finish.result_valid", 32'(rv), 32'd0);
        check("idle_finish.state", 32'(dut.state_q), 32'(StIdle));

        // Reach DONE with a failing verdict, then init together with finish.
        do_init();
        run(4'h2);
        for (int i = 0; i < 3; i++) run(4'h0);
        do_finish("pre_restart");
        init = 1'b1; finish = 1'b1;
        cycle();
        init = 1'b0; finish = 1'b0;
        sig_m = SEED; cnt_m = 0;
        check("restart.result_valid", 32'(rv), 32'd0);
        check("restart.state", 32'(dut.state_q), 32'(StArmed));
        for (int i = 0; i < 4; i++) run(4'h0);
        do_finish("restart_pass");

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
